alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle issue/sequencing unit driving the single-cycle alu (ALUOp/A/B in, C/Zero out).
//  Accepts one RV32I instruction per transaction, decodes LUI/AUIPC/ADD/ADDI and reads the
//  register file. Drives ALU opcode and operands, captures C/Zero, then issues a one-cycle
//  register write-back. Sits between fetch and the register file in the lab_final datapath.
// PARAMETERS
//  XLEN         32  datapath width (alu A/B/C width)
//  REG_AW       5   register address width
//  EXEC_CYCLES  1   cycles operands are held stable on the ALU before C is captured (>=1)
// PORTS
//  clk          in   1       system clock, rising edge
//  rstn         in   1       asynchronous active-low reset
//  instr_valid  in   1       fetch presents instr/instr_pc
//  instr_ready  out  1       unit can accept an instruction
//  instr        in   32      RV32I instruction word
//  instr_pc     in   XLEN    PC of instr
//  rs1_addr     out  REG_AW  regfile read address 1 (combinational read)
//  rs2_addr     out  REG_AW  regfile read address 2
//  rs1_data     in   XLEN    regfile read data 1
//  rs2_data     in   XLEN    regfile read data 2
//  alu_op       out  5       ALUOp to alu
//  alu_a        out  XLEN    operand A to alu
//  alu_b        out  XLEN    operand B to alu
//  alu_c        in   XLEN    alu result
//  alu_zero     in   8       alu Zero flag (bit 0 significant)
//  wb_en        out  1       one-cycle write-back strobe
//  wb_addr      out  REG_AW  destination register
//  wb_data      out  XLEN    captured ALU result
//  wb_zero      out  1       captured alu_zero[0]
//  illegal      out  1       one-cycle pulse: unsupported instruction retired
//  retire_cnt   out  32      retired-instruction count (ALU_ISSUE_RETIRE_CNT_EN only)
// BEHAVIOUR
//  - FSM IDLE->DECODE->EXEC(xEXEC_CYCLES)->WB->IDLE. instr_ready=1 only in IDLE. Accept on
//    instr_valid&&instr_ready: latch instr, instr_pc. Accept at edge T => DECODE in cycle T+1,
//    EXEC in T+2..T+1+EXEC_CYCLES, WB strobe in cycle T+2+EXEC_CYCLES; back-to-back issue
//    interval 2+EXEC_CYCLES+1 cycles.
//  - DECODE: rs1_addr=instr[19:15], rs2_addr=instr[24:20]; register rs1_data/rs2_data and
//    decoded op/operands at end of DECODE.
//  - Decode (ALUOp codes nop=0, lui=1, auipc=2, add=3):
//    0110111 LUI   op=lui   A=0        B={instr[31:12],12'b0}
//    0010111 AUIPC op=auipc A=instr_pc B={instr[31:12],12'b0}
//    0110011 f3=000 f7=0000000 ADD op=add A=rs1 B=rs2
//    0010011 f3=000 ADDI op=add A=rs1 B=sign-extended instr[31:20]
//    anything else: illegal; op=nop, A=B=0, no write-back.
//  - EXEC: alu_op/alu_a/alu_b driven from registers, stable all EXEC cycles; a down-counter
//    loaded with EXEC_CYCLES-1 on entry; alu_c/alu_zero[0] captured on the last EXEC cycle.
//  - WB: wb_en=1 for exactly one cycle unless illegal or rd (instr[11:7])==0; illegal=1 for
//    the WB cycle when illegal. wb_addr/wb_data/wb_zero hold until next WB.
//  - Outside EXEC alu_op=nop, alu_a=alu_b=0. Arithmetic is modulo 2^XLEN (alu wraps).
//  - instr_valid outside IDLE is ignored (no latch, no loss: fetch holds until ready).
//  - Reset (any state, incl. mid-EXEC): FSM to IDLE; all outputs 0 except instr_ready=1
//    after release; pending instruction discarded, no wb_en/illegal.
// CONFIGURATION
//  ALU_ISSUE_RETIRE_CNT_EN defined: retire_cnt increments by 1 on each WB cycle (legal or
//  illegal, incl. rd==0), wraps at 2^32, reset to 0. Undefined: port tied to 0, no counter.
// STRUCTURE
//  Shared package alu_pkg: ALUOp_* codes, opcode/funct constants, FSM state encodings.
//  Sub-module alu_issue_decode: combinational instr(+pc,rs data) -> op, A, B, rd, illegal.
// TESTING
//  LUI x5,0x12345 -> alu_op=1, B=0x12345000; wb_en, wb_addr=5, wb_data=0x12345000, T+3.
//  AUIPC x1,0x1 at pc=0x100 -> alu_op=2, A=0x100; wb_data=0x00001100.
//  ADD x3,x1,x2 with 7/-7 -> wb_data=0, wb_zero=1; ADDI x4,x1,-1 with x1=0 -> 0xFFFFFFFF.
//  ADDI x0,x1,5 -> no wb_en; opcode 0x00000000 -> illegal pulse, alu_op=0, no wb_en.
//  instr_valid held high continuously -> instr_ready low DECODE..WB, one accept per 4 cycles.
//  rstn low during EXEC -> no wb_en, instr_ready=1 after release; EXEC_CYCLES=3 -> wb at T+5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue unit: ALUOp codes, RV32I opcode/funct fields
// and the issue FSM state encoding.
package alu_pkg;

  localparam logic [4:0] ALUOP_NOP   = 5'd0;
  localparam logic [4:0] ALUOP_LUI   = 5'd1;
  localparam logic [4:0] ALUOP_AUIPC = 5'd2;
  localparam logic [4:0] ALUOP_ADD   = 5'd3;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } issue_state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode for the ALU issue unit: LUI/AUIPC/ADD/ADDI to ALUOp and
// operands; anything else is flagged illegal with a NOP and zero operands.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [4:0]        op,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [REG_AW-1:0] rd,
  output logic              illegal,
  output logic              wb_req
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] u_imm_s;
  logic [XLEN-1:0] i_imm_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign u_imm_s  = XLEN'({instr[31:12], 12'b0});
  assign i_imm_s  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign rd       = instr[7 +: REG_AW];

  // Opcode/funct decode to ALU operation and operands
  always_comb begin
    op      = ALUOP_NOP;
    a       = '0;
    b       = '0;
    illegal = 1'b1;
    case (opcode_s)
      OPC_LUI: begin
        op      = ALUOP_LUI;
        b       = u_imm_s;
        illegal = 1'b0;
      end
      OPC_AUIPC: begin
        op      = ALUOP_AUIPC;
        a       = pc;
        b       = u_imm_s;
        illegal = 1'b0;
      end
      OPC_OP: begin
        if ((funct3_s == F3_ADD) && (funct7_s == F7_ADD)) begin
          op      = ALUOP_ADD;
          a       = rs1_data;
          b       = rs2_data;
          illegal = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if (funct3_s == F3_ADD) begin
          op      = ALUOP_ADD;
          a       = rs1_data;
          b       = i_imm_s;
          illegal = 1'b0;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // x0 is never written, so a legal op targeting it retires without a strobe
  assign wb_req = !illegal && (rd != '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue/sequencer in front of the single-cycle alu: accept, decode, hold
// operands for EXEC_CYCLES, then strobe one write-back. Optional retired-instruction
// counter enabled by defining ALU_ISSUE_RETIRE_CNT_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   instr_pc,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [4:0]        alu_op,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_c,
  input  logic [7:0]        alu_zero,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_zero,
  output logic              illegal,
  output logic [31:0]       retire_cnt
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  issue_state_e      state_r;
  issue_state_e      state_next_s;
  logic [31:0]       instr_r;
  logic [XLEN-1:0]   pc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [4:0]        alu_op_r;
  logic [XLEN-1:0]   alu_a_r;
  logic [XLEN-1:0]   alu_b_r;
  logic [REG_AW-1:0] rd_r;
  logic              illegal_pend_r;
  logic              wb_req_r;
  logic              wb_en_r;
  logic [REG_AW-1:0] wb_addr_r;
  logic [XLEN-1:0]   wb_data_r;
  logic              wb_zero_r;
  logic              illegal_r;
  logic              exec_last_s;

  logic [4:0]        dec_op_s;
  logic [XLEN-1:0]   dec_a_s;
  logic [XLEN-1:0]   dec_b_s;
  logic [REG_AW-1:0] dec_rd_s;
  logic              dec_illegal_s;
  logic              dec_wb_req_s;
  logic              zero_unused_s;

  assign zero_unused_s = ^alu_zero[7:1];

  alu_issue_decode #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_decode (
    .instr    (instr_r),
    .pc       (pc_r),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .op       (dec_op_s),
    .a        (dec_a_s),
    .b        (dec_b_s),
    .rd       (dec_rd_s),
    .illegal  (dec_illegal_s),
    .wb_req   (dec_wb_req_s)
  );

  assign exec_last_s = (cnt_r == '0);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DECODE: state_next_s = ST_EXEC;
      ST_EXEC: begin
        if (exec_last_s) begin
          state_next_s = ST_WB;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Instruction latch, operand staging, EXEC hold counter and write-back capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instr_r        <= 32'd0;
      pc_r           <= '0;
      cnt_r          <= '0;
      alu_op_r       <= ALUOP_NOP;
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      rd_r           <= '0;
      illegal_pend_r <= 1'b0;
      wb_req_r       <= 1'b0;
      wb_en_r        <= 1'b0;
      wb_addr_r      <= '0;
      wb_data_r      <= '0;
      wb_zero_r      <= 1'b0;
      illegal_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wb_en_r   <= 1'b0;
          illegal_r <= 1'b0;
          if (instr_valid) begin
            instr_r <= instr;
            pc_r    <= instr_pc;
          end
        end
        ST_DECODE: begin
          alu_op_r       <= dec_op_s;
          alu_a_r        <= dec_a_s;
          alu_b_r        <= dec_b_s;
          rd_r           <= dec_rd_s;
          illegal_pend_r <= dec_illegal_s;
          wb_req_r       <= dec_wb_req_s;
          cnt_r          <= CNT_W'(EXEC_CYCLES - 1);
        end
        ST_EXEC: begin
          if (exec_last_s) begin
            // ALU drive drops back to NOP/0 the same edge the result is taken
            alu_op_r  <= ALUOP_NOP;
            alu_a_r   <= '0;
            alu_b_r   <= '0;
            wb_en_r   <= wb_req_r;
            illegal_r <= illegal_pend_r;
            if (wb_req_r) begin
              wb_addr_r <= rd_r;
              wb_data_r <= alu_c;
              wb_zero_r <= alu_zero[0];
            end
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        ST_WB: begin
          wb_en_r   <= 1'b0;
          illegal_r <= 1'b0;
        end
        default: begin
          alu_op_r  <= ALUOP_NOP;
          alu_a_r   <= '0;
          alu_b_r   <= '0;
          wb_en_r   <= 1'b0;
          illegal_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
  logic [31:0] retire_cnt_r;

  // Every WB cycle retires one instruction, legal or not
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt_r <= 32'd0;
    end else if (state_r == ST_WB) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_r;
`else
  assign retire_cnt = 32'd0;
`endif

  assign instr_ready = (state_r == ST_IDLE);
  assign rs1_addr    = instr_r[15 +: REG_AW];
  assign rs2_addr    = instr_r[20 +: REG_AW];
  assign alu_op      = alu_op_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign wb_en       = wb_en_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign wb_zero     = wb_zero_r;
  assign illegal     = illegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed RV32I vectors with hand-computed results.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_zero;
  logic        wb_en, wb_zero, illegal;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, retire_cnt;

  logic        instr_valid3, instr_ready3;
  logic [31:0] instr3, pc3;
  logic [4:0]  rs1_addr3, rs2_addr3;
  logic [31:0] zero32;
  logic [4:0]  alu_op3;
  logic [31:0] alu_a3, alu_b3, alu_c3;
  logic [7:0]  alu_zero3;
  logic        wb_en3, wb_zero3, illegal3;
  logic [4:0]  wb_addr3;
  logic [31:0] wb_data3, retire_cnt3;

  logic [31:0] regs [32];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zero;
    logic        ill;
    logic        wben;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } ex_exp_t;

  wb_exp_t wb_q[$];
  ex_exp_t ex_q[$];
  wb_exp_t wb_e;
  ex_exp_t ex_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference single-cycle alu
  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd1:    return b;
      5'd2:    return a + b;
      5'd3:    return a + b;
      default: return 32'd0;
    endcase
  endfunction

  assign rs1_data  = regs[rs1_addr];
  assign rs2_data  = regs[rs2_addr];
  assign alu_c     = alu_model(alu_op, alu_a, alu_b);
  assign alu_zero  = {7'd0, alu_c == 32'd0};
  assign zero32    = 32'd0;
  assign alu_c3    = alu_model(alu_op3, alu_a3, alu_b3);
  assign alu_zero3 = {7'd0, alu_c3 == 32'd0};

  alu_issue_ctrl #(.XLEN(32), .REG_AW(5), .EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rstn(rstn), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_c(alu_c), .alu_zero(alu_zero), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_zero(wb_zero), .illegal(illegal),
    .retire_cnt(retire_cnt)
  );

  alu_issue_ctrl #(.XLEN(32), .REG_AW(5), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
    .instr(instr3), .instr_pc(pc3), .rs1_addr(rs1_addr3), .rs2_addr(rs2_addr3),
    .rs1_data(zero32), .rs2_data(zero32), .alu_op(alu_op3), .alu_a(alu_a3),
    .alu_b(alu_b3), .alu_c(alu_c3), .alu_zero(alu_zero3), .wb_en(wb_en3),
    .wb_addr(wb_addr3), .wb_data(wb_data3), .wb_zero(wb_zero3), .illegal(illegal3),
    .retire_cnt(retire_cnt3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns one negedge after the accepting edge (plus settle negedges)
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input bit has_ex, input logic [4:0] eop, input logic [31:0] ea, input logic [31:0] eb,
                       input bit has_wb, input logic [4:0] eaddr, input logic [31:0] edata,
                       input logic ezero, input logic eill, input logic ewben,
                       input bit hold, input int settle, output int acc);
    ex_exp_t xe;
    wb_exp_t we;
    instr_valid = 1'b1;
    instr       = ins;
    instr_pc    = pc;
    for (int k = 0; k < 20 && !instr_ready; k++) @(negedge clk);
    if (!instr_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      acc = -1;
      instr_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (has_ex) begin
      xe.op = eop; xe.a = ea; xe.b = eb; xe.cyc = acc + 1;
      ex_q.push_back(xe);
    end
    if (has_wb) begin
      we.addr = eaddr; we.data = edata; we.zero = ezero; we.ill = eill; we.wben = ewben;
      we.cyc = acc + 2;
      wb_q.push_back(we);
    end
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  // Monitor: pops expected ALU drive and write-back events as the DUT presents them
  always @(negedge clk) begin
    if (rstn) begin
      if (alu_op != 5'd0) begin
        if (ex_q.size() == 0) begin
          chk("ex_unexpected_op", {27'd0, alu_op}, 32'd0);
        end else begin
          ex_e = ex_q.pop_front();
          chk("ex_op", {27'd0, alu_op}, {27'd0, ex_e.op});
          chk("ex_a", alu_a, ex_e.a);
          chk("ex_b", alu_b, ex_e.b);
          chk("ex_cycle", cyc, ex_e.cyc);
        end
      end
      if (wb_en || illegal) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", {30'd0, wb_en, illegal}, 32'd0);
        end else begin
          wb_e = wb_q.pop_front();
          chk("wb_en", {31'd0, wb_en}, {31'd0, wb_e.wben});
          chk("wb_illegal", {31'd0, illegal}, {31'd0, wb_e.ill});
          chk("wb_cycle", cyc, wb_e.cyc);
          if (wb_e.wben) begin
            chk("wb_addr", {27'd0, wb_addr}, {27'd0, wb_e.addr});
            chk("wb_data", wb_data, wb_e.data);
            chk("wb_zero", {31'd0, wb_zero}, {31'd0, wb_e.zero});
          end
        end
      end
    end
  end

  initial begin
    int a1, a2, a3, acc, n_exec;
    bit found;
    rstn = 1'b0; instr_valid = 1'b0; instr = 32'd0; instr_pc = 32'd0;
    instr_valid3 = 1'b0; instr3 = 32'd0; pc3 = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);

    // LUI x5,0x12345
    issue(32'h123452B7, 32'h0, 1, 5'd1, 32'h0, 32'h12345000,
          1, 5'd5, 32'h12345000, 1'b0, 1'b0, 1'b1, 0, 3, acc);
    // AUIPC x1,0x1 at pc 0x100
    issue(32'h00001097, 32'h100, 1, 5'd2, 32'h100, 32'h1000,
          1, 5'd1, 32'h00001100, 1'b0, 1'b0, 1'b1, 0, 3, acc);
    // ADD x3,x1,x2 with 7 + -7
    regs[1] = 32'd7; regs[2] = 32'hFFFFFFF9;
    issue(32'h002081B3, 32'h0, 1, 5'd3, 32'd7, 32'hFFFFFFF9,
          1, 5'd3, 32'h0, 1'b1, 1'b0, 1'b1, 0, 3, acc);
    // ADDI x4,x1,-1 with x1=0
    regs[1] = 32'd0;
    issue(32'hFFF08213, 32'h0, 1, 5'd3, 32'd0, 32'hFFFFFFFF,
          1, 5'd4, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 0, 3, acc);
    // ADDI x0,x1,5: executes, never writes back
    issue(32'h00508013, 32'h0, 1, 5'd3, 32'd0, 32'd5,
          0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 3, acc);
    // all-zero word and SUB (f7=0100000) are illegal
    issue(32'h00000000, 32'h0, 0, 5'd0, 32'd0, 32'd0,
          1, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 3, acc);
    issue(32'h402081B3, 32'h0, 0, 5'd0, 32'd0, 32'd0,
          1, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 3, acc);

    // instr_valid held high across three LUIs
    issue(32'hABCDE337, 32'h0, 1, 5'd1, 32'h0, 32'hABCDE000,
          1, 5'd6, 32'hABCDE000, 1'b0, 1'b0, 1'b1, 1, 0, a1);
    issue(32'h000013B7, 32'h0, 1, 5'd1, 32'h0, 32'h00001000,
          1, 5'd7, 32'h00001000, 1'b0, 1'b0, 1'b1, 1, 0, a2);
    issue(32'hFFFFF437, 32'h0, 1, 5'd1, 32'h0, 32'hFFFFF000,
          1, 5'd8, 32'hFFFFF000, 1'b0, 1'b0, 1'b1, 0, 3, a3);
    chk("b2b_interval_1", a2 - a1, 32'd4);
    chk("b2b_interval_2", a3 - a2, 32'd4);
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 32'd10);
`endif

    // reset asserted during EXEC of LUI x9
    issue(32'h555554B7, 32'h0, 1, 5'd1, 32'h0, 32'h55555000,
          0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, acc);
    @(negedge clk);
    #2;
    chk("mid_exec_op", {27'd0, alu_op}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_exec_op", {27'd0, alu_op}, 32'd0);
    chk("rst_exec_wb_en", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_retire", retire_cnt, 32'd0);

    // EXEC_CYCLES=3 instance: operands held three cycles, WB three edges later
    instr_valid3 = 1'b1; instr3 = 32'h123452B7; pc3 = 32'h0;
    for (int k = 0; k < 10 && !instr_ready3; k++) @(negedge clk);
    acc = cyc + 1;
    @(negedge clk);
    instr_valid3 = 1'b0;
    n_exec = 0; found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (alu_op3 == 5'd1) n_exec++;
      if (wb_en3 && !found) begin
        found = 1'b1;
        chk("ec3_wb_cycle", cyc - acc, 32'd4);
        chk("ec3_wb_data", wb_data3, 32'h12345000);
        chk("ec3_wb_addr", {27'd0, wb_addr3}, 32'd5);
      end
      @(negedge clk);
    end
    chk("ec3_wb_seen", {31'd0, found}, 32'd1);
    chk("ec3_exec_cycles", n_exec, 32'd3);

    for (int k = 0; k < 20 && (wb_q.size() != 0 || ex_q.size() != 0); k++) @(negedge clk);
    chk("wb_q_drained", wb_q.size(), 32'd0);
    chk("ex_q_drained", ex_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
